spi_frame_ctrl: RTL and testbench

- Sequences the SPI byte stream from the SPI slave byte receiver into the LED controller.
- Decodes a command byte at the start of each chip-select frame.
- Routes the following bytes to one of two places: the timing configuration registers, or the pixel RAM write port (auto-incrementing address).
- Signals the LED output engine when a complete pixel frame is ready.

---
 rtl/spi_frame_ctrl_pkg.sv | 26 ++
 rtl/spi_frame_ctrl_if.sv | 47 ++++
 rtl/spi_frame_ctrl_cs_sync_edge.sv | 29 ++
 rtl/spi_frame_ctrl.sv | 173 +++++++++++++++++
 tb/tb_spi_frame_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/spi_frame_ctrl_pkg.sv
// Shared constants and types for the SPI frame controller: command bytes,
// FSM state encoding and configuration register indices.
package spi_frame_pkg;

  localparam logic [7:0] CMD_CONF_WR = 8'h2A;
  localparam logic [7:0] CMD_DATA_WR = 8'h2C;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CMD  = 3'd1,
    CONF = 3'd2,
    DATA = 3'd3,
    DROP = 3'd4
  } state_t;

  localparam logic [2:0] CFG_IDX_T0H  = 3'd0;
  localparam logic [2:0] CFG_IDX_T1H  = 3'd1;
  localparam logic [2:0] CFG_IDX_TBIT = 3'd2;
  localparam logic [2:0] CFG_IDX_TRST = 3'd3;
  localparam logic [2:0] CFG_IDX_DONE = 3'd4;

  function automatic logic [7:0] xor_accum(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

endpackage

// File: rtl/spi_frame_ctrl_if.sv
// Byte-stream, pixel RAM write and configuration bundle of spi_frame_ctrl.
// Adds chk_err_out when SPI_FRAME_XOR_CHK_EN is defined.
interface spi_frame_ctrl_if #(
  parameter int RAM_AW = 32'd11
);
  logic              spi_cs_n_in;
  logic              byte_rdy_in;
  logic [7:0]        byte_data_in;
  logic              ram_wr_en_out;
  logic [RAM_AW-1:0] ram_wr_addr_out;
  logic [7:0]        ram_wr_data_out;
  logic [7:0]        cfg_t0h_out;
  logic [7:0]        cfg_t1h_out;
  logic [7:0]        cfg_tbit_out;
  logic [7:0]        cfg_trst_out;
  logic              frame_rdy_out;
  logic              ovf_out;
`ifdef SPI_FRAME_XOR_CHK_EN
  logic              chk_err_out;

  modport master (
    output spi_cs_n_in, byte_rdy_in, byte_data_in,
    input  ram_wr_en_out, ram_wr_addr_out, ram_wr_data_out,
    input  cfg_t0h_out, cfg_t1h_out, cfg_tbit_out, cfg_trst_out,
    input  frame_rdy_out, ovf_out, chk_err_out
  );
  modport slave (
    input  spi_cs_n_in, byte_rdy_in, byte_data_in,
    output ram_wr_en_out, ram_wr_addr_out, ram_wr_data_out,
    output cfg_t0h_out, cfg_t1h_out, cfg_tbit_out, cfg_trst_out,
    output frame_rdy_out, ovf_out, chk_err_out
  );
`else
  modport master (
    output spi_cs_n_in, byte_rdy_in, byte_data_in,
    input  ram_wr_en_out, ram_wr_addr_out, ram_wr_data_out,
    input  cfg_t0h_out, cfg_t1h_out, cfg_tbit_out, cfg_trst_out,
    input  frame_rdy_out, ovf_out
  );
  modport slave (
    input  spi_cs_n_in, byte_rdy_in, byte_data_in,
    output ram_wr_en_out, ram_wr_addr_out, ram_wr_data_out,
    output cfg_t0h_out, cfg_t1h_out, cfg_tbit_out, cfg_trst_out,
    output frame_rdy_out, ovf_out
  );
`endif
endinterface

// File: rtl/spi_frame_ctrl_cs_sync_edge.sv
// Two-flop synchroniser for the raw SPI chip select plus rise/fall detection.
// Flops reset to 1 (deasserted chip select) so reset never creates an edge.
module cs_sync_edge (
  input  logic clk_in,
  input  logic rst_in,
  input  logic cs_n_raw,
  output logic cs_fall,
  output logic cs_rise
);
  logic sync1_r;
  logic sync2_r;
  logic prev_r;

  // Synchroniser chain and previous-level register for edge detection
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
      prev_r  <= 1'b1;
    end else begin
      sync1_r <= cs_n_raw;
      sync2_r <= sync1_r;
      prev_r  <= sync2_r;
    end
  end

  assign cs_fall = prev_r & ~sync2_r;
  assign cs_rise = ~prev_r & sync2_r;
endmodule

// File: rtl/spi_frame_ctrl.sv
// Frame sequencer between the SPI byte receiver and the LED controller.
// Optional trailing-XOR frame check enabled by SPI_FRAME_XOR_CHK_EN.
module spi_frame_ctrl
  import spi_frame_pkg::*;
#(
  parameter int         RAM_AW       = 32'd11,
  parameter logic [7:0] CFG_T0H_DEF  = 8'd16,
  parameter logic [7:0] CFG_T1H_DEF  = 8'd40,
  parameter logic [7:0] CFG_TBIT_DEF = 8'd63,
  parameter logic [7:0] CFG_TRST_DEF = 8'd255
) (
  input logic             clk_in,
  input logic             rst_in,
  spi_frame_ctrl_if.slave bus
);
  localparam logic [RAM_AW-1:0] ADDR_ZERO = {RAM_AW{1'b0}};
  localparam logic [RAM_AW-1:0] ADDR_MAX  = {RAM_AW{1'b1}};
  localparam logic [RAM_AW-1:0] ADDR_ONE  = {{(RAM_AW-1){1'b0}}, 1'b1};

  state_t            state_r, state_s;
  logic              cs_fall_s, cs_rise_s;
  logic              cmd_byte_s, conf_byte_s, data_byte_s, wr_s, frame_end_s;
  logic              frame_ok_s;
  logic [RAM_AW-1:0] addr_r, wr_addr_r;
  logic [7:0]        wr_data_r;
  logic              wr_en_r, full_r, wrote_r, ovf_r, frame_rdy_r;
  logic [2:0]        cfg_idx_r;
  logic [7:0]        t0h_r, t1h_r, tbit_r, trst_r;

  cs_sync_edge u_cs_sync_edge (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .cs_n_raw (bus.spi_cs_n_in),
    .cs_fall  (cs_fall_s),
    .cs_rise  (cs_rise_s)
  );

  assign cmd_byte_s  = bus.byte_rdy_in && (state_r == CMD);
  assign conf_byte_s = bus.byte_rdy_in && (state_r == CONF) && (cfg_idx_r < CFG_IDX_DONE);
  assign data_byte_s = bus.byte_rdy_in && (state_r == DATA);
  assign wr_s        = data_byte_s && !full_r;
  // A byte arriving with the closing edge still counts toward this frame
  assign frame_end_s = cs_rise_s && (state_r == DATA) && (wrote_r || wr_s);

`ifdef SPI_FRAME_XOR_CHK_EN
  logic [7:0] xor_r, xor_next_s;
  logic       chk_err_r, chk_bad_s;

  // Running XOR including a byte accepted on the frame-closing cycle
  always_comb begin
    xor_next_s = xor_r;
    if (data_byte_s) begin
      xor_next_s = xor_accum(xor_r, bus.byte_data_in);
    end else begin
      xor_next_s = xor_r;
    end
    frame_ok_s = frame_end_s && (xor_next_s == 8'h00);
    chk_bad_s  = frame_end_s && (xor_next_s != 8'h00);
  end

  // Checksum accumulator and error pulse
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      xor_r     <= 8'h00;
      chk_err_r <= 1'b0;
    end else begin
      chk_err_r <= chk_bad_s;
      if (cmd_byte_s && (bus.byte_data_in == CMD_DATA_WR)) begin
        xor_r <= 8'h00;
      end else begin
        xor_r <= xor_next_s;
      end
    end
  end

  assign bus.chk_err_out = chk_err_r;
`else
  assign frame_ok_s = frame_end_s;
`endif

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next state: frame edges take priority over byte decoding
  always_comb begin
    state_s = state_r;
    if (cs_rise_s) begin
      state_s = IDLE;
    end else if (cs_fall_s) begin
      state_s = CMD;
    end else if (cmd_byte_s) begin
      case (bus.byte_data_in)
        CMD_CONF_WR: state_s = CONF;
        CMD_DATA_WR: state_s = DATA;
        default:     state_s = DROP;
      endcase
    end else begin
      state_s = state_r;
    end
  end

  // Byte routing: RAM write port, address tracking, overflow and config registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_en_r     <= 1'b0;
      wr_addr_r   <= ADDR_ZERO;
      wr_data_r   <= 8'h00;
      addr_r      <= ADDR_ZERO;
      full_r      <= 1'b0;
      wrote_r     <= 1'b0;
      ovf_r       <= 1'b0;
      frame_rdy_r <= 1'b0;
      cfg_idx_r   <= CFG_IDX_DONE;
      t0h_r       <= CFG_T0H_DEF;
      t1h_r       <= CFG_T1H_DEF;
      tbit_r      <= CFG_TBIT_DEF;
      trst_r      <= CFG_TRST_DEF;
    end else begin
      wr_en_r     <= wr_s;
      frame_rdy_r <= frame_ok_s;
      if (wr_s) begin
        wr_addr_r <= addr_r;
        wr_data_r <= bus.byte_data_in;
      end
      if (cmd_byte_s && (bus.byte_data_in == CMD_DATA_WR)) begin
        addr_r  <= ADDR_ZERO;
        full_r  <= 1'b0;
        wrote_r <= 1'b0;
        ovf_r   <= 1'b0;
      end else if (data_byte_s) begin
        if (full_r) begin
          ovf_r <= 1'b1;
        end else begin
          wrote_r <= 1'b1;
          // Address saturates at the last location; later bytes are dropped
          if (addr_r == ADDR_MAX) begin
            full_r <= 1'b1;
          end else begin
            addr_r <= addr_r + ADDR_ONE;
          end
        end
      end
      if (cmd_byte_s && (bus.byte_data_in == CMD_CONF_WR)) begin
        cfg_idx_r <= CFG_IDX_T0H;
      end else if (conf_byte_s) begin
        cfg_idx_r <= cfg_idx_r + 3'd1;
        case (cfg_idx_r)
          CFG_IDX_T0H:  t0h_r  <= bus.byte_data_in;
          CFG_IDX_T1H:  t1h_r  <= bus.byte_data_in;
          CFG_IDX_TBIT: tbit_r <= bus.byte_data_in;
          CFG_IDX_TRST: trst_r <= bus.byte_data_in;
          default:      ;
        endcase
      end
    end
  end

  assign bus.ram_wr_en_out   = wr_en_r;
  assign bus.ram_wr_addr_out = wr_addr_r;
  assign bus.ram_wr_data_out = wr_data_r;
  assign bus.cfg_t0h_out     = t0h_r;
  assign bus.cfg_t1h_out     = t1h_r;
  assign bus.cfg_tbit_out    = tbit_r;
  assign bus.cfg_trst_out    = trst_r;
  assign bus.frame_rdy_out   = frame_rdy_r;
  assign bus.ovf_out         = ovf_r;
endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Self-checking bench for spi_frame_ctrl (RAM_AW=2): frame table plus corner sequences.
// Expected RAM writes go through a scoreboard queue popped by a negedge monitor.
module tb_spi_frame_ctrl;
  localparam int AW = 2;
`ifdef SPI_FRAME_XOR_CHK_EN
  localparam bit XM = 1'b1;
`else
  localparam bit XM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_frame_ctrl_if #(.RAM_AW(AW)) bus ();
  spi_frame_ctrl #(.RAM_AW(AW)) dut (.clk_in(clk), .rst_in(rst), .bus(bus.slave));

  typedef struct packed {logic [AW-1:0] addr; logic [7:0] data;} wr_t;
  typedef struct {
    int          n;
    logic [63:0] b;
    logic [31:0] cfg;
    int          frm;
    int          err;
    logic        ovf;
  } vec_t;

  wr_t  sb[$];
  vec_t vecs[10];
  int   checks = 0, errors = 0;
  int   frm_cnt = 0, err_cnt = 0;

  int         mst;
  int         midx, maddr;
  bit         mfull;
  logic       movf;
  logic [7:0] mcfg[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int efrm(input bit xok);
    return (XM && !xok) ? 0 : 1;
  endfunction
  function automatic int eerr(input bit xok);
    return (XM && !xok) ? 1 : 0;
  endfunction

  // Monitor: pop scoreboard on each write, count output pulses
  always @(negedge clk) begin : mon
    wr_t e;
    if (bus.ram_wr_en_out === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_wr_addr", 32'(bus.ram_wr_addr_out), 32'hFFFF_FFFF);
      end else begin
        e = sb.pop_front();
        check("wr_addr", 32'(bus.ram_wr_addr_out), 32'(e.addr));
        check("wr_data", 32'(bus.ram_wr_data_out), 32'(e.data));
      end
    end
    if (bus.frame_rdy_out === 1'b1) frm_cnt++;
`ifdef SPI_FRAME_XOR_CHK_EN
    if (bus.chk_err_out === 1'b1) err_cnt++;
`endif
  end

  function automatic logic [31:0] dut_cfg();
    return {bus.cfg_t0h_out, bus.cfg_t1h_out, bus.cfg_tbit_out, bus.cfg_trst_out};
  endfunction

  task automatic model_reset();
    mcfg[0] = 8'd16; mcfg[1] = 8'd40; mcfg[2] = 8'd63; mcfg[3] = 8'd255;
    movf = 1'b0; mst = 0; midx = 4; maddr = 0; mfull = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    case (mst)
      1: begin
        if (b == 8'h2A) begin mst = 2; midx = 0; end
        else if (b == 8'h2C) begin mst = 3; maddr = 0; mfull = 1'b0; movf = 1'b0; end
        else mst = 4;
      end
      2: if (midx < 4) begin mcfg[midx] = b; midx++; end
      3: begin
        if (mfull) movf = 1'b1;
        else begin
          sb.push_back('{addr: AW'(maddr), data: b});
          if (maddr == (1 << AW) - 1) mfull = 1'b1;
          else maddr++;
        end
      end
      default: ;
    endcase
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bus.byte_rdy_in = 1'b1; bus.byte_data_in = b;
    model_byte(b);
    @(negedge clk);
    bus.byte_rdy_in = 1'b0;
    #1;
    check("wr_pending", 32'(sb.size()), 32'd0);
    check("cfg_step", dut_cfg(), {mcfg[0], mcfg[1], mcfg[2], mcfg[3]});
    check("ovf_step", 32'(bus.ovf_out), 32'(movf));
  endtask

  task automatic cs_start();
    @(negedge clk);
    bus.spi_cs_n_in = 1'b0;
    repeat (4) @(negedge clk);
    mst = 1;
  endtask

  task automatic run_frame(input int k);
    int f0, e0;
    f0 = frm_cnt; e0 = err_cnt;
    cs_start();
    for (int i = 0; i < vecs[k].n; i++) send_byte(vecs[k].b[63-8*i -: 8]);
    repeat (2) @(negedge clk);
    bus.spi_cs_n_in = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    mst = 0;
    check($sformatf("v%0d_frame_rdy", k), 32'(frm_cnt - f0), 32'(vecs[k].frm));
    check($sformatf("v%0d_chk_err", k), 32'(err_cnt - e0), 32'(vecs[k].err));
    check($sformatf("v%0d_cfg", k), dut_cfg(), vecs[k].cfg);
    check($sformatf("v%0d_ovf", k), 32'(bus.ovf_out), 32'(vecs[k].ovf));
  endtask

  task automatic check_defaults(input string tag);
    check({tag, "_wr_en"}, 32'(bus.ram_wr_en_out), 32'd0);
    check({tag, "_wr_addr"}, 32'(bus.ram_wr_addr_out), 32'd0);
    check({tag, "_wr_data"}, 32'(bus.ram_wr_data_out), 32'd0);
    check({tag, "_cfg"}, dut_cfg(), 32'h10283FFF);
    check({tag, "_ovf"}, 32'(bus.ovf_out), 32'd0);
    check({tag, "_frame_rdy"}, 32'(bus.frame_rdy_out), 32'd0);
  endtask

  initial begin
    int f0, e0;
    rst = 1'b1;
    bus.spi_cs_n_in = 1'b1; bus.byte_rdy_in = 1'b0; bus.byte_data_in = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    #1;
    check_defaults("reset");
    rst = 1'b0;

    vecs[0] = '{5, 64'h2A10203040000000, 32'h10203040, 0, 0, 1'b0};
    vecs[1] = '{4, 64'h2CAABBCC00000000, 32'h10203040, efrm(1'b0), eerr(1'b0), 1'b0};
    vecs[2] = '{3, 64'h5501020000000000, 32'h10203040, 0, 0, 1'b0};
    vecs[3] = '{7, 64'h2C11223344556600, 32'h10203040, efrm(1'b0), eerr(1'b0), 1'b1};
    vecs[4] = '{2, 64'h2C77000000000000, 32'h10203040, efrm(1'b0), eerr(1'b0), 1'b0};
    vecs[5] = '{7, 64'h2A01020304050600, 32'h01020304, 0, 0, 1'b0};
    vecs[6] = '{1, 64'h2C00000000000000, 32'h01020304, 0, 0, 1'b0};
    vecs[7] = '{2, 64'h2A09000000000000, 32'h09020304, 0, 0, 1'b0};
    vecs[8] = '{4, 64'h2C01020300000000, 32'h09020304, efrm(1'b1), eerr(1'b1), 1'b0};
    vecs[9] = '{4, 64'h2C01020400000000, 32'h09020304, efrm(1'b0), eerr(1'b0), 1'b0};
    for (int k = 0; k < 10; k++) run_frame(k);

    // Only data byte arrives together with the synchronised cs rise
    f0 = frm_cnt; e0 = err_cnt;
    cs_start();
    send_byte(8'h2C);
    @(negedge clk);
    bus.spi_cs_n_in = 1'b1;
    repeat (2) @(negedge clk);
    bus.byte_rdy_in = 1'b1; bus.byte_data_in = 8'h00;
    model_byte(8'h00);
    @(negedge clk);
    bus.byte_rdy_in = 1'b0;
    #1;
    check("simul_wr_en", 32'(bus.ram_wr_en_out), 32'd1);
    check("simul_frame_rdy", 32'(bus.frame_rdy_out), 32'd1);
    repeat (4) @(negedge clk);
    #1;
    mst = 0;
    check("simul_wr_pending", 32'(sb.size()), 32'd0);
    check("simul_frame_cnt", 32'(frm_cnt - f0), 32'd1);
    check("simul_err_cnt", 32'(err_cnt - e0), 32'd0);

    // Reset in the middle of an overflowing data frame
    cs_start();
    send_byte(8'h2C);
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    check("pre_rst_ovf", 32'(bus.ovf_out), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_defaults("midrst");
    model_reset();
    f0 = frm_cnt; e0 = err_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    bus.spi_cs_n_in = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    check("midrst_frame_cnt", 32'(frm_cnt - f0), 32'd0);
    check("midrst_err_cnt", 32'(err_cnt - e0), 32'd0);
    check("midrst_cfg_after", dut_cfg(), 32'h10283FFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
